// File: rtl/n64_ctrl_responder.sv
// n64_ctrl_responder
//   Device (controller) side of the N64 single-wire open-drain joybus. Receives an 8-bit
//   console command, then answers 0x00/0xFF (info/reset) with a 24-bit ID and 0x01 (poll)
//   with a 32-bit button word. Any other command is ignored until the line has idled.
//
// Ports:
//   clk        system clock (33 MHz board clock by default)
//   reset_n    asynchronous active-low reset
//   din        raw data-line level, asynchronous to clk
//   dout_oe    1 = pull the line low, 0 = release (pull-up gives high)
//   buttons    button/stick word, bit 31 sent first, captured at the end of the stop bit
//   cmd        last fully received command byte
//   cmd_valid  one-cycle pulse when cmd updates
//   busy       high whenever the FSM is not IDLE
//
// Optional build macro N64_RESP_STATS_EN adds:
//   poll_count completed 0x01 responses (wraps at 16 bits)
//   err_count  receive timeouts plus ignored commands (wraps at 16 bits)

module n64_ctrl_responder #(
    parameter int unsigned CLK_PER_US    = 33,
    parameter int unsigned RESP_DELAY_US = 2,
    parameter int unsigned TIMEOUT_US    = 8,
    parameter logic [7:0]  PAK_STATUS    = 8'h02
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        din,
    output logic        dout_oe,
    input  logic [31:0] buttons,
    output logic [7:0]  cmd,
    output logic        cmd_valid,
    output logic        busy
`ifdef N64_RESP_STATS_EN
    ,
    output logic [15:0] poll_count,
    output logic [15:0] err_count
`endif
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] RX_BIT    = 3'd1;
    localparam logic [2:0] RX_STOP   = 3'd2;
    localparam logic [2:0] RESP_WAIT = 3'd3;
    localparam logic [2:0] TX_BIT    = 3'd4;
    localparam logic [2:0] TX_STOP   = 3'd5;
    localparam logic [2:0] GUARD     = 3'd6;
    localparam logic [2:0] IGNORE    = 3'd7;

    localparam logic [15:0] T1          = 16'(CLK_PER_US);
    localparam logic [15:0] T2          = 16'(2 * CLK_PER_US);
    localparam logic [15:0] T3          = 16'(3 * CLK_PER_US);
    localparam logic [15:0] T4          = 16'(4 * CLK_PER_US);
    localparam logic [15:0] RESP_LEN    = 16'(RESP_DELAY_US * CLK_PER_US);
    localparam logic [15:0] TIMEOUT_LEN = 16'(TIMEOUT_US * CLK_PER_US);

    logic        din_meta_q, din_sync_q, din_prev_q;
    logic [2:0]  state_q, state_d;
    logic [15:0] timer_q, timer_d, timer_inc;
    logic [15:0] high_q, high_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic        sampled_q, sampled_d;
    logic        stop_low_q, stop_low_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [31:0] resp_q, resp_d;
    logic        poll_q, poll_d;
    logic [7:0]  cmd_q, cmd_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic        oe_q, oe_d;
    logic        err_inc, poll_inc;
    logic        fall, rise, line_timeout;

    assign fall         = din_prev_q & ~din_sync_q;
    assign rise         = ~din_prev_q & din_sync_q;
    // high_q counts consecutive synchronised-high cycles, saturating
    assign line_timeout = din_sync_q && (high_q >= TIMEOUT_LEN);
    assign timer_inc    = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;
    assign high_d       = !din_sync_q ? 16'd0 :
                          (high_q == 16'hFFFF) ? high_q : high_q + 16'd1;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_inc;
        bit_cnt_d   = bit_cnt_q;
        sampled_d   = sampled_q;
        stop_low_d  = stop_low_q;
        shreg_d     = shreg_q;
        resp_d      = resp_q;
        poll_d      = poll_q;
        cmd_d       = cmd_q;
        cmd_valid_d = 1'b0;
        oe_d        = 1'b0;
        err_inc     = 1'b0;
        poll_inc    = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = 16'd0;
                if (fall) begin
                    state_d   = RX_BIT;
                    bit_cnt_d = 5'd0;
                    sampled_d = 1'b0;
                end
            end
            RX_BIT: begin
                if (!sampled_q && timer_q == T2) begin
                    shreg_d   = {shreg_q[6:0], din_sync_q};
                    sampled_d = 1'b1;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd7) begin
                        state_d    = RX_STOP;
                        stop_low_d = 1'b0;
                    end
                end else if (sampled_q && fall) begin
                    timer_d   = 16'd0;
                    sampled_d = 1'b0;
                end else if (line_timeout) begin
                    state_d = IDLE;
                    err_inc = 1'b1;
                end
            end
            RX_STOP: begin
                if (fall) begin
                    stop_low_d = 1'b1;
                end
                if (stop_low_q && rise) begin
                    cmd_d       = shreg_q;
                    cmd_valid_d = 1'b1;
                    timer_d     = 16'd0;
                    bit_cnt_d   = 5'd0;
                    if (shreg_q == 8'h00 || shreg_q == 8'hFF) begin
                        // Left-aligned so the transmitter always shifts out bit 31
                        resp_d  = {8'h05, 8'h00, PAK_STATUS, 8'h00};
                        poll_d  = 1'b0;
                        state_d = RESP_WAIT;
                    end else if (shreg_q == 8'h01) begin
                        resp_d  = buttons;
                        poll_d  = 1'b1;
                        state_d = RESP_WAIT;
                    end else begin
                        state_d = IGNORE;
                        err_inc = 1'b1;
                    end
                end else if (line_timeout) begin
                    state_d = IDLE;
                    err_inc = 1'b1;
                end
            end
            RESP_WAIT: begin
                if (timer_q == RESP_LEN - 16'd1) begin
                    state_d = TX_BIT;
                    timer_d = 16'd0;
                end
            end
            TX_BIT: begin
                oe_d = resp_q[31] ? (timer_q < T1) : (timer_q < T3);
                if (timer_q == T4 - 16'd1) begin
                    timer_d   = 16'd0;
                    resp_d    = {resp_q[30:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == (poll_q ? 5'd31 : 5'd23)) begin
                        state_d = TX_STOP;
                    end
                end
            end
            TX_STOP: begin
                oe_d = 1'b1;
                if (timer_q == T2 - 16'd1) begin
                    state_d  = GUARD;
                    timer_d  = 16'd0;
                    poll_inc = poll_q;
                end
            end
            GUARD: begin
                if (timer_q == T1 - 16'd1) begin
                    // A console edge coinciding with the exit is taken straight away
                    if (fall) begin
                        state_d   = RX_BIT;
                        timer_d   = 16'd0;
                        bit_cnt_d = 5'd0;
                        sampled_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            IGNORE: begin
                if (line_timeout) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // Synchroniser resets to the idle (released) level so no false edge appears
            din_meta_q  <= 1'b1;
            din_sync_q  <= 1'b1;
            din_prev_q  <= 1'b1;
            state_q     <= IDLE;
            timer_q     <= 16'd0;
            high_q      <= 16'd0;
            bit_cnt_q   <= 5'd0;
            sampled_q   <= 1'b0;
            stop_low_q  <= 1'b0;
            shreg_q     <= 8'h00;
            resp_q      <= 32'h0;
            poll_q      <= 1'b0;
            cmd_q       <= 8'h00;
            cmd_valid_q <= 1'b0;
            oe_q        <= 1'b0;
        end else begin
            din_meta_q  <= din;
            din_sync_q  <= din_meta_q;
            din_prev_q  <= din_sync_q;
            state_q     <= state_d;
            timer_q     <= timer_d;
            high_q      <= high_d;
            bit_cnt_q   <= bit_cnt_d;
            sampled_q   <= sampled_d;
            stop_low_q  <= stop_low_d;
            shreg_q     <= shreg_d;
            resp_q      <= resp_d;
            poll_q      <= poll_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            oe_q        <= oe_d;
        end
    end

    assign dout_oe   = oe_q;
    assign cmd       = cmd_q;
    assign cmd_valid = cmd_valid_q;
    assign busy      = (state_q != IDLE);

`ifdef N64_RESP_STATS_EN
    logic [15:0] poll_count_q, err_count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            poll_count_q <= 16'h0000;
            err_count_q  <= 16'h0000;
        end else begin
            if (poll_inc) poll_count_q <= poll_count_q + 16'd1;
            if (err_inc)  err_count_q  <= err_count_q + 16'd1;
        end
    end

    assign poll_count = poll_count_q;
    assign err_count  = err_count_q;
`else
    logic unused_stats;
    assign unused_stats = poll_inc ^ err_inc;
`endif

endmodule

// File: doc/n64_ctrl_responder.md
Name: n64_ctrl_responder

Overview:
- Device-side (controller-emulator) end of the N64 single-wire, open-drain joybus protocol. It is the counterpart to the console-side poller/receiver.
- Listens for an 8-bit console command on the shared data line and decodes it.
- Answers 0x00/0xFF (info/reset) with a 24-bit ID and 0x01 (poll) with a 32-bit button word.
- Runs on the 33 MHz board clock; the top level converts dout_oe into the tri-state pin.

Parameters:
- CLK_PER_US, 33, clock cycles per microsecond; all protocol timings derive from it.
- RESP_DELAY_US, 2, idle gap between the console stop-bit release and the first response bit.
- TIMEOUT_US, 8, line-high time during command reception that aborts the frame.
- PAK_STATUS, 8'h02, third byte of the info response (0x01 = pak present, 0x02 = no pak).

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- din, input, 1, raw data-line level; asynchronous to clk.
- dout_oe, output, 1, 1 = pull line low; 0 = release (pull-up gives high).
- buttons, input, 32, button/stick word, bit 31 sent first.
- cmd, output, 8, last fully received command byte.
- cmd_valid, output, 1, one-cycle pulse when cmd updates.
- busy, output, 1, high whenever the FSM is not IDLE.

Behaviour:
- Reset (async assert, sync release) values:
  - dout_oe=0, cmd=8'h00, cmd_valid=0, busy=0.
  - FSM=IDLE; all counters 0.
- Synchroniser: din goes through a 2-FF synchroniser. All edge detection uses the synchronised value; fixed 2-cycle input latency.
- Bit timing (T = CLK_PER_US):
  - Bit cell = 4T.
  - Console '0' = 3T low then 1T high; '1' = 1T low then 3T high.
- States:
  - IDLE: wait for a falling edge, then go to RX_BIT with bit_cnt=0 and timer=0.
  - RX_BIT:
    - At timer=2T after the falling edge, shift the sampled level into the command register, MSB first: high = 1, low = 0.
    - Then wait for the next falling edge.
    - After the 8th sample, go to RX_STOP.
    - If the line stays high ≥ TIMEOUT_US*T while waiting, go to IDLE with no cmd_valid.
  - RX_STOP:
    - Wait for the stop-bit falling edge, then its rising edge.
    - On the rising edge: load cmd, pulse cmd_valid one cycle, decode:
      - 0x00 or 0xFF → response register = {8'h05, 8'h00, PAK_STATUS}, length 24.
      - 0x01 → response register = buttons (captured this exact cycle), length 32.
      - Any other value → IGNORE.
    - A stop-bit timeout (same limit as RX_BIT) → IDLE, no cmd_valid.
  - RESP_WAIT: count RESP_DELAY_US*T cycles, then go to TX_BIT. din is ignored.
  - TX_BIT:
    - Send MSB first: '0' = dout_oe high 3T then low 1T; '1' = dout_oe high 1T then low 3T.
    - After the last bit, go to TX_STOP.
  - TX_STOP: dout_oe high 2T, release, then go to GUARD.
  - GUARD: wait 1T with din ignored (absorbs own-release echo and synchroniser latency), then go to IDLE.
  - IGNORE: wait until the line has been continuously high for TIMEOUT_US*T, then go to IDLE.
- Self-echo: din is never interpreted in RESP_WAIT, TX_BIT, TX_STOP or GUARD.
- buttons changes after the capture cycle do not affect the frame in flight.
- Mid-frame reset: dout_oe drops to 0 immediately (async) and the FSM restarts in IDLE. The first frame after release may be lost.
- Timers are wide enough for TIMEOUT_US*T with the default parameters. Counters do not wrap within a frame.
- A falling edge arriving in IDLE on the same cycle as GUARD exit is accepted.

Optional Feature:
- Macro: N64_RESP_STATS_EN.
- Defined:
  - Adds outputs poll_count[15:0] and err_count[15:0].
  - poll_count increments on every completed 0x01 response (at TX_STOP exit).
  - err_count increments on every RX timeout and every IGNORE entry.
  - Both wrap 0xFFFF→0x0000 and reset to 0.
- Undefined: neither port nor logic exists; all other behaviour is identical.

Test Plan:
- Console sends 0x01 + stop, buttons=32'hA5C3_0F81 → cmd_valid pulse with cmd=8'h01 → after 66 idle cycles, 32 bits A5C30F81 MSB first, '1' = 33 low/99 high, '0' = 99 low/33 high → 66-cycle stop low → busy low after GUARD.
- Console sends 0x00 with PAK_STATUS=8'h01 → response 24'h050001 + stop. Repeat with 0xFF → identical response.
- Console sends 0x02 → cmd_valid with cmd=8'h02, dout_oe stays 0, FSM returns to IDLE after 264 high cycles; with N64_RESP_STATS_EN defined, err_count=1.
- Console sends 5 bits then holds the line high for 300 cycles → no cmd_valid, dout_oe never asserts, next valid 0x01 frame answered normally.
- reset_n pulled low at bit 10 of a poll response → dout_oe=0 within the same cycle; after release, the next 0x01 is answered correctly.
- buttons toggled to 32'h0 one cycle after the capture cycle → transmitted word still equals the captured value. With N64_RESP_STATS_EN defined, after 65536 polls poll_count=16'h0000.
